// File: rtl/chan_arb_fifo.sv
// chan_arb_fifo: NCHAN independent FIFOs (DEPTH words each) feeding one
// registered output through an arbiter.
//
// Build option: define CHAN_ARB_FIFO_RR_EN for round-robin arbitration
// (search restarts just after the last granted channel). Left undefined,
// the lowest-indexed non-empty channel always wins and there is no
// arbiter pointer state.
//
// Handshake rule (both sides): a word crosses an interface at a rising
// edge where valid and ready are both 1. in_ready depends only on
// registered state (ready_en and the channel count), never on out_ready
// or in_valid. out_valid/out_data/out_chan come straight from flops and
// hold steady while out_valid=1 and out_ready=0.
`timescale 1ns/1ps
module chan_arb_fifo #(
  parameter int INWIDTH = 8,
  parameter int DEPTH   = 4,
  parameter int NCHAN   = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NCHAN*INWIDTH-1:0]                    in_data,
  input  logic [NCHAN-1:0]                            in_valid,
  output logic [NCHAN-1:0]                            in_ready,
  output logic [INWIDTH-1:0]                          out_data,
  output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] out_chan,
  output logic                                        out_valid,
  input  logic                                        out_ready
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Input side is held off until the first edge after reset release.
  logic                     ready_en;
  logic [NCHAN-1:0]         push;
  logic [NCHAN-1:0]         pop;
  logic [NCHAN-1:0]         nonempty;
  logic [NCHAN*INWIDTH-1:0] head_flat;
  logic [CW-1:0]            grant;
  logic                     any_ne;
  logic                     load;
  logic [INWIDTH-1:0]       head_sel;

  // ready_en drops asynchronously with reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Per-channel storage, pointers and occupancy.
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic [INWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               rdy;

    // Full is judged on the pre-edge count, so a pop on a full channel
    // does not open room for a push in the same cycle.
    assign rdy         = ready_en & (count != FULL_CNT);
    assign in_ready[c] = rdy;
    assign push[c]     = in_valid[c] & rdy;
    assign nonempty[c] = (count != '0);
    assign head_flat[c*INWIDTH +: INWIDTH] = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
      if (push[c]) begin
        mem[wr_ptr] <= in_data[c*INWIDTH +: INWIDTH];
      end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[c]) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop[c]) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push[c], pop[c]})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef CHAN_ARB_FIFO_RR_EN
  logic [CW-1:0]    rr_ptr;
  logic [NCHAN-1:0] ne_rot;
  logic [CW-1:0]    offset;
  logic [CW:0]      gsum;
  logic [CW:0]      rr_nxt;

  // Round-robin: rotate the request vector so rr_ptr sits at bit 0, pick the
  // lowest set bit, then map the offset back to a channel number.
  always_comb begin
    ne_rot = NCHAN'({nonempty, nonempty} >> rr_ptr);
    offset = '0;
    any_ne = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!any_ne && ne_rot[i]) begin
        offset = CW'(i);
        any_ne = 1'b1;
      end
    end
    gsum = {1'b0, rr_ptr} + {1'b0, offset};
    if (gsum >= (CW+1)'(NCHAN)) begin
      gsum = gsum - (CW+1)'(NCHAN);
    end
    grant = gsum[CW-1:0];
  end

  // Next search starts one past the channel just granted, modulo NCHAN.
  always_comb begin
    rr_nxt = {1'b0, grant} + (CW+1)'(1);
    if (rr_nxt >= (CW+1)'(NCHAN)) begin
      rr_nxt = '0;
    end
  end

  // Arbiter pointer advances only when a word is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= rr_nxt[CW-1:0];
    end
  end
`else
  // Fixed priority: lowest-indexed non-empty channel wins.
  always_comb begin
    grant  = '0;
    any_ne = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!any_ne && nonempty[i]) begin
        grant  = CW'(i);
        any_ne = 1'b1;
      end
    end
  end
`endif

  // Output register takes a new word when empty or being drained this edge.
  assign load = (!out_valid || out_ready) && any_ne;

  // Pop strobe to the granted channel and mux of its head word.
  always_comb begin
    pop      = '0;
    head_sel = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (grant == CW'(i)) begin
        pop[i]   = load;
        head_sel = head_flat[i*INWIDTH +: INWIDTH];
      end
    end
  end

  // Registered output stage: load, hold under backpressure, or go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= head_sel;
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_arb_fifo.sv
// Bench for chan_arb_fifo at default parameters (INWIDTH=8, DEPTH=4,
// NCHAN=2). Arbitration expectations follow CHAN_ARB_FIFO_RR_EN.
`timescale 1ns/1ps
module tb_chan_arb_fifo;

  localparam int INWIDTH = 8;
  localparam int DEPTH   = 4;
  localparam int NCHAN   = 2;
  localparam int CW      = 1;
  localparam int SW      = CW + INWIDTH;

  typedef struct {
    int                 chan;
    logic [INWIDTH-1:0] data;
    int                 exp_chan;
    logic [INWIDTH-1:0] exp_data;
  } lat_vec_t;

  // ---------------- clock / reset ----------------
  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NCHAN*INWIDTH-1:0] in_data = '0;
  logic [NCHAN-1:0]         in_valid = '0;
  logic [NCHAN-1:0]         in_ready;
  logic [INWIDTH-1:0]       out_data;
  logic [CW-1:0]            out_chan;
  logic                     out_valid;
  logic                     out_ready = 1'b0;

  always #5 clk = ~clk;

  chan_arb_fifo #(.INWIDTH(INWIDTH), .DEPTH(DEPTH), .NCHAN(NCHAN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    in_valid = v;
    in_data  = {d1, d0};
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: a transfer seen here happens at the next
  // rising edge. Outputs are matched against the oldest queued word of the
  // same channel, which checks per-channel ordering.
  int sb_idx;
  bit sb_found;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        sb_found = 1'b0;
        sb_idx   = 0;
        foreach (exp_q[i]) begin
          if (!sb_found && exp_q[i][SW-1:INWIDTH] == out_chan) begin
            sb_found = 1'b1;
            sb_idx   = i;
          end
        end
        if (!sb_found) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got chan %0d data 0x%0h, expected nothing queued", out_chan, out_data);
        end else begin
          check("sb_data", {24'h0, out_data}, {24'h0, exp_q[sb_idx][INWIDTH-1:0]});
          exp_q.delete(sb_idx);
        end
      end
      for (int c = 0; c < NCHAN; c++) begin
        if (in_valid[c] && in_ready[c]) begin
          exp_q.push_back({CW'(c), in_data[c*INWIDTH +: INWIDTH]});
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    lat_vec_t vecs[6];
    int       exp_seq[6];
    int       n;
    logic     acc;

    vecs[0] = '{chan: 0, data: 8'hA5, exp_chan: 0, exp_data: 8'hA5};
    vecs[1] = '{chan: 1, data: 8'h5A, exp_chan: 1, exp_data: 8'h5A};
    vecs[2] = '{chan: 0, data: 8'h00, exp_chan: 0, exp_data: 8'h00};
    vecs[3] = '{chan: 1, data: 8'hFF, exp_chan: 1, exp_data: 8'hFF};
    vecs[4] = '{chan: 0, data: 8'h3C, exp_chan: 0, exp_data: 8'h3C};
    vecs[5] = '{chan: 0, data: 8'hC3, exp_chan: 0, exp_data: 8'hC3};
`ifdef CHAN_ARB_FIFO_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 1, 1, 1};
`endif

    // Reset and release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {30'h0, in_ready}, 0);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_data", {24'h0, out_data}, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_pre_edge", {30'h0, in_ready}, 0);
    tick();
    check("rel_in_ready_post_edge", {30'h0, in_ready}, 32'h3);
    check("rel_out_valid", {31'h0, out_valid}, 0);
    check("rel_out_data", {24'h0, out_data}, 0);

    // Latency vectors: accept at edge k, visible after k+1, gone after k+2.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].chan == 0) drive(2'b01, vecs[i].data, 8'h00);
      else                   drive(2'b10, 8'h00, vecs[i].data);
      tick();
      drive(2'b00, 8'h00, 8'h00);
      check($sformatf("lat%0d_valid_k", i), {31'h0, out_valid}, 0);
      tick();
      check($sformatf("lat%0d_valid_k1", i), {31'h0, out_valid}, 1);
      check($sformatf("lat%0d_data", i), {24'h0, out_data}, {24'h0, vecs[i].exp_data});
      check($sformatf("lat%0d_chan", i), {31'h0, out_chan}, vecs[i].exp_chan);
      tick();
      check($sformatf("lat%0d_valid_k2", i), {31'h0, out_valid}, 0);
    end

    // Full: with output stalled, ch1 takes DEPTH words in its FIFO plus one
    // in the output register, then in_ready[1] drops.
    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 8'h00, 8'(8'h30 + n));
      acc = in_ready[1];
      tick();
      if (acc) n++;
    end
    check("full_accepts", n, DEPTH + 1);
    check("full_in_ready", {31'h0, in_ready[1]}, 0);
    out_ready = 1'b1;
    check("full_no_push_on_pop_edge", {31'h0, in_ready[1]}, 0);
    tick();
    check("full_ready_after_pop", {31'h0, in_ready[1]}, 1);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 30 && (exp_q.size() != 0 || out_valid); i++) tick();
    check("full_drained", {31'h0, (exp_q.size() == 0 && !out_valid)}, 1);

    // Arbitration: 3 words on each channel, then drain at full rate.
    out_ready = 1'b0;
    drive(2'b11, 8'h40, 8'h50);
    tick();
    drive(2'b11, 8'h41, 8'h51);
    tick();
    drive(2'b11, 8'h42, 8'h52);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("arb%0d_valid", i), {31'h0, out_valid}, 1);
      check($sformatf("arb%0d_chan", i), {31'h0, out_chan}, exp_seq[i]);
      tick();
    end
    check("arb_idle", {31'h0, out_valid}, 0);

    // Backpressure: output must hold its first word for 5 stalled cycles.
    out_ready = 1'b0;
    drive(2'b01, 8'hC3, 8'h00);
    tick();
    drive(2'b11, 8'h11, 8'h22);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), {31'h0, out_valid}, 1);
      check($sformatf("bp%0d_data", i), {24'h0, out_data}, 32'hC3);
      check($sformatf("bp%0d_chan", i), {31'h0, out_chan}, 0);
      tick();
    end

    // Mid-operation reset: takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'h0, out_valid}, 0);
    check("mrst_out_data", {24'h0, out_data}, 0);
    check("mrst_in_ready", {30'h0, in_ready}, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_rel_in_ready_pre", {30'h0, in_ready}, 0);
    tick();
    check("mrst_rel_in_ready_post", {30'h0, in_ready}, 32'h3);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("mrst_fifos_empty", {31'h0, out_valid}, 0);
    drive(2'b10, 8'h00, 8'h77);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    tick();
    check("mrst_next_valid", {31'h0, out_valid}, 1);
    check("mrst_next_data", {24'h0, out_data}, 32'h77);
    check("mrst_next_chan", {31'h0, out_chan}, 1);
    tick();
    check("mrst_next_idle", {31'h0, out_valid}, 0);

    // ---------------- report ----------------
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
